// File: rtl/piso_dbuf_if.sv
// Handshake bundle for piso_dbuf: wide word input side plus narrow chunk output side.
// The master modport is the environment (producer + consumer); the slave modport is the converter.
interface piso_dbuf_if #(
  parameter int OUT_WIDTH = 8,
  parameter int N_CHUNKS  = 4
) ();
  localparam int IN_WIDTH  = OUT_WIDTH * N_CHUNKS;
  localparam int LEN_WIDTH = $clog2(N_CHUNKS + 1);

  logic                 i_flush;
  logic [IN_WIDTH-1:0]  i_data;
  logic [LEN_WIDTH-1:0] i_len;
  logic                 i_msb_first;
  logic                 i_valid;
  logic                 o_ready;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_valid;
  logic                 o_last;
  logic                 i_ready;
  logic                 o_idle;

  modport master (
    output i_flush, i_data, i_len, i_msb_first, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_idle
  );

  modport slave (
    input  i_flush, i_data, i_len, i_msb_first, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_last, o_idle
  );
endinterface

// File: rtl/piso_dbuf.sv
// Double-buffered parallel-in/serial-out converter: an active shift entry feeds the output
// while a pending entry holds the next word, so back-to-back words stream without bubbles.
module piso_dbuf #(
  parameter int OUT_WIDTH = 8,
  parameter int N_CHUNKS  = 4
) (
  input logic        i_clk,
  input logic        i_rst,
  piso_dbuf_if.slave bus
);
  localparam int IN_WIDTH  = OUT_WIDTH * N_CHUNKS;
  localparam int LEN_WIDTH = $clog2(N_CHUNKS + 1);

  typedef logic [IN_WIDTH-1:0]  word_t;
  typedef logic [OUT_WIDTH-1:0] chunk_t;
  typedef logic [LEN_WIDTH-1:0] len_t;

  // The active shift register always carries the chunk on o_data at its head.
  function automatic chunk_t head(word_t w, logic msb);
    return msb ? w[IN_WIDTH-1 -: OUT_WIDTH] : w[OUT_WIDTH-1:0];
  endfunction

  function automatic word_t advance(word_t w, logic msb);
    return msb ? (w << OUT_WIDTH) : (w >> OUT_WIDTH);
  endfunction

  word_t  act_sr_q,    act_sr_d;
  len_t   act_cnt_q,   act_cnt_d;
  logic   act_msb_q,   act_msb_d;
  word_t  pend_data_q, pend_data_d;
  len_t   pend_len_q,  pend_len_d;
  logic   pend_msb_q,  pend_msb_d;
  logic   pend_full_q, pend_full_d;
  chunk_t o_data_q,    o_data_d;
  logic   o_valid_q,   o_valid_d;
  logic   o_last_q,    o_last_d;
  logic   o_ready_q,   o_ready_d;

  logic   hs, retire, accept;
  len_t   eff_len;

  assign eff_len = (bus.i_len == '0 || bus.i_len > len_t'(N_CHUNKS)) ? len_t'(N_CHUNKS)
                                                                      : bus.i_len;
  assign hs      = o_valid_q && bus.i_ready;
  assign retire  = hs && (act_cnt_q == len_t'(1));
  assign accept  = bus.i_valid && o_ready_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    act_sr_d    = act_sr_q;
    act_cnt_d   = act_cnt_q;
    act_msb_d   = act_msb_q;
    pend_data_d = pend_data_q;
    pend_len_d  = pend_len_q;
    pend_msb_d  = pend_msb_q;
    pend_full_d = pend_full_q;

    if (bus.i_flush) begin
      act_cnt_d   = '0;
      pend_full_d = 1'b0;
    end else begin
      if (retire) begin
        if (pend_full_q) begin
          act_sr_d    = pend_data_q;
          act_cnt_d   = pend_len_q;
          act_msb_d   = pend_msb_q;
          pend_full_d = 1'b0;
        end else begin
          act_cnt_d = '0;
        end
      end else if (hs) begin
        act_sr_d  = advance(act_sr_q, act_msb_q);
        act_cnt_d = act_cnt_q - len_t'(1);
      end

      // accept implies pending is empty, so a retiring active entry is free for bypass.
      if (accept) begin
        if (act_cnt_q == '0 || retire) begin
          act_sr_d  = bus.i_data;
          act_cnt_d = eff_len;
          act_msb_d = bus.i_msb_first;
        end else begin
          pend_data_d = bus.i_data;
          pend_len_d  = eff_len;
          pend_msb_d  = bus.i_msb_first;
          pend_full_d = 1'b1;
        end
      end
    end

    o_valid_d = (act_cnt_d != '0);
    o_last_d  = (act_cnt_d == len_t'(1));
    o_data_d  = o_valid_d ? head(act_sr_d, act_msb_d) : '0;
    o_ready_d = ~pend_full_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_sr_q    <= '0;
      act_cnt_q   <= '0;
      act_msb_q   <= 1'b0;
      pend_data_q <= '0;
      pend_len_q  <= '0;
      pend_msb_q  <= 1'b0;
      pend_full_q <= 1'b0;
      o_data_q    <= '0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      o_ready_q   <= 1'b1;
    end else begin
      act_sr_q    <= act_sr_d;
      act_cnt_q   <= act_cnt_d;
      act_msb_q   <= act_msb_d;
      pend_data_q <= pend_data_d;
      pend_len_q  <= pend_len_d;
      pend_msb_q  <= pend_msb_d;
      pend_full_q <= pend_full_d;
      o_data_q    <= o_data_d;
      o_valid_q   <= o_valid_d;
      o_last_q    <= o_last_d;
      o_ready_q   <= o_ready_d;
    end
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_ready = o_ready_q;
  assign bus.o_idle  = (act_cnt_q == '0) && !pend_full_q;
endmodule

// File: tb/tb_piso_dbuf.sv
// Randomised and directed bench for piso_dbuf against a word-queue reference model:
// the model holds accepted words and the index of the next chunk to emit from each.
module tb_piso_dbuf;
  localparam int OW = 8;
  localparam int NC = 4;
  localparam int IW = OW * NC;
  localparam int LW = $clog2(NC + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_dbuf_if #(.OUT_WIDTH(OW), .N_CHUNKS(NC)) bus ();
  piso_dbuf #(.OUT_WIDTH(OW), .N_CHUNKS(NC)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    logic [IW-1:0] data;
    int            len;
    bit            msb;
    int            pos;
  } mword_t;

  mword_t mq[$];
  bit     m_ready  = 1'b1;
  bit     last_acc = 1'b0;
  int     total    = 0;
  int     bad      = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] mchunk(mword_t w);
    int idx;
    idx = w.msb ? (NC - 1 - w.pos) : w.pos;
    return w.data[idx*OW +: OW];
  endfunction

  task automatic compare(string tag);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'(mq.size() > 0));
    check({tag, ".ready"}, 32'(bus.o_ready), 32'(m_ready));
    check({tag, ".idle"},  32'(bus.o_idle),  32'(mq.size() == 0));
    if (mq.size() > 0) begin
      check({tag, ".data"}, 32'(bus.o_data), 32'(mchunk(mq[0])));
      check({tag, ".last"}, 32'(bus.o_last), 32'(mq[0].pos == mq[0].len - 1));
    end else begin
      check({tag, ".last"}, 32'(bus.o_last), 32'd0);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks.
  task automatic cyc(string tag, bit v, logic [IW-1:0] d, int len, bit msb, bit rdy, bit fl);
    mword_t w;
    bit     acc;
    bus.i_valid     = v;
    bus.i_data      = d;
    bus.i_len       = len[LW-1:0];
    bus.i_msb_first = msb;
    bus.i_ready     = rdy;
    bus.i_flush     = fl;
    @(posedge clk);
    acc = v && m_ready && !fl;
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && rdy) begin
        w = mq[0];
        w.pos++;
        if (w.pos == w.len) void'(mq.pop_front());
        else mq[0] = w;
      end
      if (acc) begin
        w.data = d;
        w.len  = (len == 0 || len > NC) ? NC : len;
        w.msb  = msb;
        w.pos  = 0;
        mq.push_back(w);
      end
    end
    m_ready  = (mq.size() < 2);
    last_acc = acc;
    #1;
    compare(tag);
  endtask

  task automatic idle_cycles(string tag, int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(string tag);
    check({tag, ".data"},  32'(bus.o_data),  32'd0);
    check({tag, ".valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, ".last"},  32'(bus.o_last),  32'd0);
    check({tag, ".ready"}, 32'(bus.o_ready), 32'd1);
    check({tag, ".idle"},  32'(bus.o_idle),  32'd1);
  endtask

  logic [IW-1:0] words[3] = '{32'h0102_0304, 32'h1112_1314, 32'h2122_2324};
  logic [IW-1:0] held;
  int            held_len;
  bit            held_msb, have;
  int            k, vcount;

  initial begin
    rst             = 1'b1;
    bus.i_flush     = 1'b0;
    bus.i_data      = '0;
    bus.i_len       = '0;
    bus.i_msb_first = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic MSB-first, len=0 means full width.
    cyc("msb", 1'b1, 32'hAABB_CCDD, 0, 1'b1, 1'b1, 1'b0);
    check("msb.first", 32'(bus.o_data), 32'hAA);
    idle_cycles("msb", 5);

    // LSB-first, two chunks only.
    cyc("lsb", 1'b1, 32'h1122_3344, 2, 1'b0, 1'b1, 1'b0);
    check("lsb.first", 32'(bus.o_data), 32'h44);
    idle_cycles("lsb", 4);

    // Back-to-back, upstream holds each word until accepted.
    k      = 0;
    vcount = 0;
    for (int i = 0; i < 30 && k < 3; i++) begin
      cyc("b2b", 1'b1, words[k], 4, 1'b1, 1'b1, 1'b0);
      if (last_acc) k++;
      if (bus.o_valid) vcount++;
    end
    check("b2b.accepted", 32'(k), 32'd3);
    for (int i = 0; i < 16; i++) begin
      cyc("b2b_drain", 1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
      if (bus.o_valid) vcount++;
    end
    check("b2b.valid_cycles", 32'(vcount), 32'd12);

    // Backpressure mid-word with a second word parked in pending.
    cyc("bp", 1'b1, 32'hC0C1_C2C3, 4, 1'b1, 1'b1, 1'b0);
    cyc("bp", 1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
    cyc("bp_stall", 1'b1, 32'hD0D1_D2D3, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("bp_stall", 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    check("bp.held_chunk", 32'(bus.o_data), 32'hC1);
    check("bp.ready_low", 32'(bus.o_ready), 32'd0);
    idle_cycles("bp_drain", 10);

    // Flush with active mid-word and pending full, input offered in the flush cycle.
    cyc("fl", 1'b1, 32'hE0E1_E2E3, 4, 1'b1, 1'b1, 1'b0);
    cyc("fl", 1'b1, 32'hF0F1_F2F3, 4, 1'b1, 1'b1, 1'b0);
    cyc("fl_cut", 1'b1, 32'h5A5A_5A5A, 4, 1'b1, 1'b1, 1'b1);
    check_reset_values("fl_after");
    cyc("fl_ready", 1'b1, 32'h6B6B_6B6B, 4, 1'b1, 1'b1, 1'b1);
    check_reset_values("fl_drop");
    cyc("fl_next", 1'b1, 32'h9192_9394, 3, 1'b0, 1'b1, 1'b0);
    idle_cycles("fl_next", 5);
    cyc("fl_idle", 1'b0, '0, 0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-word, then length-1 words back-to-back.
    cyc("rst", 1'b1, 32'h7172_7374, 4, 1'b1, 1'b1, 1'b0);
    cyc("rst", 1'b0, '0, 0, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    mq.delete();
    m_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc("len1", 1'b1, 32'h8000_0000 | 32'(i), 1, i[0], 1'b1, 1'b0);
      check("len1.last", 32'(bus.o_last), 32'd1);
    end
    idle_cycles("len1", 2);

    // Random traffic with a holding upstream and occasional flush.
    have = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!have) begin
        held     = $urandom();
        held_len = $urandom_range(0, 7);
        held_msb = $urandom_range(0, 1) == 1;
        have     = 1'b1;
      end
      cyc("rnd", $urandom_range(0, 3) != 0, held, held_len, held_msb,
          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
      if (last_acc) have = 1'b0;
    end
    idle_cycles("rnd_drain", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
